citron_bus_master: RTL and testbench
====================================

# citron_bus_master

Single-outstanding Citron bus initiator. It converts a host-side valid/ready request into one Citron transaction and returns the read data or an error through a held response. Debug and peripheral targets (simulation console, finish register, UART) attach to its bus side. Host side is little-endian; bus data is big-endian, so the most significant byte (`[31:24]`) carries the first byte in memory.

## Interface
Parameters:
- `TIMEOUT`, default 256: maximum number of cycles a matched target may stall; 0 disables the timeout.
- `SWAP_BYTES`, default 1: when 1, byte-reverse write data toward the bus and read data toward the host; when 0, pass data through unchanged.

Ports:
- `clk_i`  in  1  sole clock; all logic on the rising edge.
- `rst_ni`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  Citron address.
- `req_wdata`  in  32  write data, host byte order.
- `resp_valid`  out  1  response held.
- `resp_ready`  in  1  host consumes the response.
- `resp_rdata`  out  32  read data, host byte order; 0 for writes and for errors.
- `resp_err`  out  1  no target matched, or timeout.
- `citron_addr`  out  8  bus address.
- `citron_rdy`  out  1  transaction strobe.
- `citron_wr`  out  1  write qualifier.
- `citron_writedata`  out  32  bus write data.
- `citron_readdata`  in  32  OR of all target read data.
- `citron_stall`  in  1  OR of all target stalls.
- `citron_match`  in  1  OR of all target address decodes.

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`: register `citron_addr`←`req_addr`, `citron_wr`←`req_wr`, `citron_writedata`←swap(`req_wdata`).
  - Clear the stall counter and go to BUS.
- **BUS:** `citron_rdy`=1, and `citron_wr` is driven as registered. Evaluate in priority order:
  1. `!citron_match`: set `resp_err`=1, `resp_rdata`=0, go to RESP. A stall from a non-matching decode is ignored.
  2. `citron_match && !citron_stall`: set `resp_err`=0. `resp_rdata`←swap(`citron_readdata`) for a read, 0 for a write. Go to RESP.
  3. `citron_match && citron_stall`:
     - If `TIMEOUT`≠0 and counter==`TIMEOUT`-1: set `resp_err`=1, `resp_rdata`=0, go to RESP.
     - Otherwise increment the counter and stay in BUS with address, wr and data unchanged.
- **RESP:**
  - `resp_valid`=1; `resp_rdata` and `resp_err` are stable.
  - On `resp_ready`, go to IDLE.
  - `req_ready`=0, so a new request cannot be accepted in the same cycle.
- Outside BUS: `citron_rdy`=0 and `citron_wr`=0. `citron_addr` and `citron_writedata` hold their last values.
- Stall counter width: $clog2(`TIMEOUT`+1), minimum 1. It saturates and never wraps.
- `swap(x)` = `{x[7:0],x[15:8],x[23:16],x[31:24]}` when `SWAP_BYTES`=1; identity otherwise.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Reset values, including while `rst_ni` is low:
  - `req_ready`=0 (goes high the first cycle after `rst_ni` rises).
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `citron_rdy`=0, `citron_wr`=0, `citron_addr`=0, `citron_writedata`=0.
- Latency from acceptance edge E:
  - `citron_rdy` is high in cycle E+1.
  - With no stall, `resp_valid` is high in cycle E+2.
  - Each stall cycle adds one cycle.
- Timeout: with `TIMEOUT`=N and a permanent stall, `citron_rdy` stays high exactly N cycles, then `resp_err` rises.
- Throughput: at most one transaction per 3 cycles.
- Reset during BUS or RESP: `citron_rdy` drops asynchronously, no response is produced, and the FSM returns to IDLE.
- Targets sample on any cycle where `citron_rdy && !citron_stall`. A write is therefore seen exactly once by a non-stalling target.

## Test plan
- Write `req_addr`=0xFF, `req_wdata`=0x0000_0041 with a non-stalling target matching: exactly one cycle has `citron_rdy`=1, `citron_wr`=1, `citron_writedata`=0x4100_0000. Then `resp_valid`=1, `resp_err`=0.
- Read from a target that stalls 3 cycles and then returns 0x1122_3344: `citron_rdy` is high for 4 cycles, `resp_rdata`=0x4433_2211, `resp_err`=0, and `resp_valid` rises at E+5.
- Read of `req_addr`=0x10 with `citron_match`=0: after one bus cycle, `resp_err`=1, `resp_rdata`=0.
- `TIMEOUT`=4 with stall and match held high: `citron_rdy` is high 4 cycles, then `resp_err`=1. Repeat with `TIMEOUT`=0: the stall is held for 1000 cycles and no response is produced.
- `resp_ready` held low for 10 cycles in RESP: `resp_valid`, `resp_rdata` and `resp_err` are stable and `req_ready`=0 throughout. `req_ready`=1 the cycle after `resp_ready`.
- Assert `rst_ni` low during a stalled BUS: `citron_rdy`=0 immediately. After release, `req_ready`=1 and a new write completes normally.

Source files
------------

// File: rtl/citron_bus_master.sv
// Single-outstanding Citron bus initiator: turns one host request into one bus
// transaction and holds the response (read data or error) until the host takes it.
module citron_bus_master #(
  parameter int unsigned TIMEOUT    = 256,
  parameter bit          SWAP_BYTES = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  citron_addr,
  output logic        citron_rdy,
  output logic        citron_wr,
  output logic [31:0] citron_writedata,
  input  logic [31:0] citron_readdata,
  input  logic        citron_stall,
  input  logic        citron_match
);

  localparam int unsigned     CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e          state_q, state_d;
  logic            started_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  function automatic logic [31:0] swap(input logic [31:0] x);
    if (SWAP_BYTES) return {x[7:0], x[15:8], x[23:16], x[31:24]};
    else            return x;
  endfunction

  // started_q keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && started_q) begin
          addr_d  = req_addr;
          wr_d    = req_wr;
          wdata_d = swap(req_wdata);
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // A stall only counts when some target actually decoded the address.
        if (!citron_match) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (!citron_stall) begin
          err_d   = 1'b0;
          rdata_d = wr_q ? 32'h0 : swap(citron_readdata);
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && started_q;
    resp_valid = (state_q == RESP);
    citron_rdy = (state_q == BUS);
    citron_wr  = (state_q == BUS) && wr_q;
  end

  assign resp_rdata       = rdata_q;
  assign resp_err         = err_q;
  assign citron_addr      = addr_q;
  assign citron_writedata = wdata_q;

endmodule

// File: tb/tb_citron_bus_master.sv
// Bench for citron_bus_master: four instances (default, TIMEOUT=4, TIMEOUT=0,
// no byte swap) share bus-side stimulus; each test drives one instance's req_valid.
module tb_citron_bus_master;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid [4];
  logic        reqWr;
  logic [7:0]  reqAddr;
  logic [31:0] reqWdata;
  logic        respReady;
  logic [31:0] citronReaddata;
  logic        citronStall;
  logic        citronMatch;

  logic        reqReady        [4];
  logic        respValid       [4];
  logic        respErr         [4];
  logic [31:0] respRdata       [4];
  logic [7:0]  citronAddr      [4];
  logic        citronRdy       [4];
  logic        citronWr        [4];
  logic [31:0] citronWritedata [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    citron_bus_master #(
      .TIMEOUT   (g == 1 ? 4 : (g == 2 ? 0 : 256)),
      .SWAP_BYTES(g == 3 ? 1'b0 : 1'b1)
    ) uDut (
      .clk_i           (clk),
      .rst_ni          (rstN),
      .req_valid       (reqValid[g]),
      .req_ready       (reqReady[g]),
      .req_wr          (reqWr),
      .req_addr        (reqAddr),
      .req_wdata       (reqWdata),
      .resp_valid      (respValid[g]),
      .resp_ready      (respReady),
      .resp_rdata      (respRdata[g]),
      .resp_err        (respErr[g]),
      .citron_addr     (citronAddr[g]),
      .citron_rdy      (citronRdy[g]),
      .citron_wr       (citronWr[g]),
      .citron_writedata(citronWritedata[g]),
      .citron_readdata (citronReaddata),
      .citron_stall    (citronStall),
      .citron_match    (citronMatch)
    );
  end

  function automatic int toOf(input int s);
    return (s == 1) ? 4 : ((s == 2) ? 0 : 256);
  endfunction

  // Reference byte reversal: byte b of the result is byte 3-b of the input.
  function automatic logic [31:0] modelSwap(input logic [31:0] x, input bit en);
    logic [31:0] y;
    for (int b = 0; b < 4; b++) y[8*b +: 8] = x[8*(3-b) +: 8];
    return en ? y : x;
  endfunction

  // One full transaction on instance s; the target stalls for the first stallN bus cycles.
  task automatic run_txn(input int s, input bit wr, input logic [7:0] addr,
                         input logic [31:0] wdata, input bit match, input int stallN,
                         input logic [31:0] rd, input int holdN, input string tag);
    int          to;
    int          expRdy;
    bit          expErr;
    logic [31:0] expData;
    logic [31:0] expBus;
    int          rdyCnt;
    bit          busBad;
    bit          holdBad;
    bit          timedOut;
    to     = toOf(s);
    expBus = modelSwap(wdata, s != 3);
    if (!match) begin
      expRdy = 1; expErr = 1'b1; expData = 32'h0;
    end else if (to != 0 && stallN >= to) begin
      expRdy = to; expErr = 1'b1; expData = 32'h0;
    end else begin
      expRdy = stallN + 1; expErr = 1'b0;
      expData = wr ? 32'h0 : modelSwap(rd, s != 3);
    end

    @(negedge clk);
    checks++;
    if (reqReady[s] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s ready_before: got %b want 1", tag, reqReady[s]);
    end
    reqValid[s] = 1'b1; reqWr = wr; reqAddr = addr; reqWdata = wdata; respReady = 1'b0;
    citronMatch = match; citronStall = 1'b1; citronReaddata = $urandom;
    @(posedge clk);
    @(negedge clk);
    reqValid[s] = 1'b0; reqWdata = $urandom; reqAddr = 8'($urandom); reqWr = 1'($urandom);

    rdyCnt = 0; busBad = 1'b0; timedOut = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      if (citronRdy[s] !== 1'b1) begin
        timedOut = 1'b0;
        break;
      end
      rdyCnt++;
      if (citronAddr[s] !== addr || citronWr[s] !== wr || citronWritedata[s] !== expBus ||
          respValid[s] !== 1'b0)
        busBad = 1'b1;
      citronStall    = match ? (rdyCnt <= stallN) : 1'b1;
      citronReaddata = (match && rdyCnt > stallN) ? rd : $urandom;
      @(negedge clk);
    end

    checks++;
    if (timedOut || rdyCnt != expRdy) begin
      failures++;
      $display("[TB] FAIL %s rdy_cycles: got %0d want %0d (bound hit=%0b)", tag, rdyCnt, expRdy, timedOut);
    end
    checks++;
    if (busBad) begin
      failures++;
      $display("[TB] FAIL %s bus_fields: addr/wr/wdata not %h/%b/%h during BUS", tag, addr, wr, expBus);
    end
    if (timedOut) return;

    checks++;
    if (respValid[s] !== 1'b1 || reqReady[s] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s resp_valid: got valid=%b ready=%b want 1/0", tag, respValid[s], reqReady[s]);
    end
    checks++;
    if (respErr[s] !== expErr) begin
      failures++;
      $display("[TB] FAIL %s resp_err: got %b want %b", tag, respErr[s], expErr);
    end
    checks++;
    if (respRdata[s] !== expData) begin
      failures++;
      $display("[TB] FAIL %s resp_rdata: got %h want %h", tag, respRdata[s], expData);
    end

    citronStall = 1'b0;
    holdBad = 1'b0;
    for (int i = 0; i < holdN; i++) begin
      citronReaddata = $urandom;
      @(negedge clk);
      if (respValid[s] !== 1'b1 || respErr[s] !== expErr || respRdata[s] !== expData ||
          reqReady[s] !== 1'b0 || citronRdy[s] !== 1'b0)
        holdBad = 1'b1;
    end
    checks++;
    if (holdBad) begin
      failures++;
      $display("[TB] FAIL %s resp_hold: response changed while resp_ready low (%0d cycles)", tag, holdN);
    end

    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    checks++;
    if (reqReady[s] !== 1'b1 || respValid[s] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s after_consume: got ready=%b valid=%b want 1/0", tag, reqReady[s], respValid[s]);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    for (int i = 0; i < 4; i++) reqValid[i] = 1'b0;
    reqWr = 1'b0; reqAddr = 8'h0; reqWdata = 32'h0; respReady = 1'b0;
    citronReaddata = 32'h0; citronStall = 1'b0; citronMatch = 1'b0;
    #23;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (reqReady[i] !== 1'b0 || respValid[i] !== 1'b0 || respErr[i] !== 1'b0 ||
          respRdata[i] !== 32'h0 || citronRdy[i] !== 1'b0 || citronWr[i] !== 1'b0 ||
          citronAddr[i] !== 8'h0 || citronWritedata[i] !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_values[%0d]: ready=%b valid=%b err=%b rdata=%h rdy=%b wr=%b addr=%h wdata=%h want all 0",
                 i, reqReady[i], respValid[i], respErr[i], respRdata[i], citronRdy[i], citronWr[i],
                 citronAddr[i], citronWritedata[i]);
      end
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++;
    if (reqReady[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_at_release: got %b want 0", reqReady[0]);
    end
    @(negedge clk);
    checks++;
    if (reqReady[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_release: got %b want 1", reqReady[0]);
    end
  endtask

  task automatic test_write();
    run_txn(0, 1'b1, 8'hFF, 32'h0000_0041, 1'b1, 0, 32'hDEAD_BEEF, 1, "write_ff");
  endtask

  task automatic test_stalled_read();
    run_txn(0, 1'b0, 8'h22, 32'h0, 1'b1, 3, 32'h1122_3344, 0, "stalled_read");
  endtask

  task automatic test_no_match();
    run_txn(0, 1'b0, 8'h10, 32'h0, 1'b0, 0, 32'hCAFE_F00D, 0, "no_match");
  endtask

  task automatic test_timeout();
    run_txn(1, 1'b0, 8'h30, 32'h0, 1'b1, 50, 32'h1234_5678, 0, "timeout4");
    run_txn(1, 1'b0, 8'h31, 32'h0, 1'b1, 3, 32'h1234_5678, 0, "timeout4_edge");
    run_txn(2, 1'b1, 8'h32, 32'hA5A5_0001, 1'b1, 1000, 32'h0, 0, "timeout0_long");
  endtask

  task automatic test_resp_hold();
    run_txn(0, 1'b0, 8'h44, 32'h0, 1'b1, 1, 32'h0102_0304, 10, "resp_hold");
  endtask

  task automatic test_no_swap();
    run_txn(3, 1'b1, 8'h05, 32'h0000_0041, 1'b1, 0, 32'h0, 0, "noswap_write");
    run_txn(3, 1'b0, 8'h06, 32'h0, 1'b1, 2, 32'h1122_3344, 0, "noswap_read");
  endtask

  task automatic test_reset_midbus();
    @(negedge clk);
    reqValid[0] = 1'b1; reqWr = 1'b0; reqAddr = 8'h77; citronMatch = 1'b1; citronStall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (citronRdy[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midbus_rdy: got %b want 1", citronRdy[0]);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (citronRdy[0] !== 1'b0 || reqReady[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midbus_async_drop: got rdy=%b ready=%b want 0/0", citronRdy[0], reqReady[0]);
    end
    @(negedge clk);
    checks++;
    if (respValid[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midbus_no_resp: got %b want 0", respValid[0]);
    end
    rstN = 1'b1;
    citronStall = 1'b0;
    run_txn(0, 1'b1, 8'h12, 32'h8765_4321, 1'b1, 0, 32'h0, 0, "after_reset_write");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), $urandom,
              $urandom_range(0, 9) != 0, int'($urandom_range(0, 6)), $urandom,
              int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_stalled_read();
    test_no_match();
    test_timeout();
    test_resp_hold();
    test_no_swap();
    test_reset_midbus();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
